// File: rtl/lisp_mem_pkg.sv
// Shared definitions for clients of the cons-cell memory unit: command codes,
// widths and cell field layout.
package lisp_mem_pkg;

  localparam int MEM_ADDR_W = 10;
  localparam int MEM_DATA_W = 24;
  localparam int NIL_ADDR   = 0;

  localparam int CAR_HI = 19;
  localparam int CAR_LO = 10;
  localparam int CDR_HI = 9;
  localparam int CDR_LO = 0;

  typedef enum logic [1:0] {
    GET_CAR      = 2'b00,
    GET_CDR      = 2'b01,
    GET_CONS     = 2'b10,
    GET_CONTENTS = 2'b11
  } mu_func_t;

  function automatic logic [MEM_ADDR_W-1:0] cell_car(input logic [MEM_DATA_W-1:0] w);
    return w[CAR_HI:CAR_LO];
  endfunction

  function automatic logic [MEM_ADDR_W-1:0] cell_cdr(input logic [MEM_DATA_W-1:0] w);
    return w[CDR_HI:CDR_LO];
  endfunction

endpackage

// File: rtl/mu_cmd_port.sv
// Memory-unit command sequencer: issues one command when the unit is ready,
// skips the stale-ready cycle, then reports the result.
module mu_cmd_port
  import lisp_mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  mu_func_t          cmd_func,
  input  logic [ADDR_W-1:0] cmd_addr,
  output logic              resp_valid,
  output logic [ADDR_W-1:0] resp_addr,
  output logic [DATA_W-1:0] resp_data,
  output logic [1:0]        mu_func,
  output logic              mu_execute,
  output logic [ADDR_W-1:0] mu_addr0,
  input  logic              mu_is_ready,
  input  logic [ADDR_W-1:0] mu_addr_out,
  input  logic [DATA_W-1:0] mu_data_out
);

  typedef enum logic [1:0] {P_IDLE, P_ISSUE, P_SETTLE, P_WAIT} port_state_t;

  port_state_t state_q, state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= P_IDLE;
      mu_func  <= '0;
      mu_addr0 <= '0;
    end else begin
      state_q <= state_d;
      if (cmd_valid && state_q == P_IDLE) begin
        mu_func  <= cmd_func;
        mu_addr0 <= cmd_addr;
      end
    end
  end

  // Ready is still high in the cycle after the strobe, so SETTLE ignores it.
  always_comb begin
    state_d    = state_q;
    mu_execute = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      P_IDLE:   if (cmd_valid) state_d = P_ISSUE;
      P_ISSUE: begin
        if (mu_is_ready) begin
          mu_execute = 1'b1;
          state_d    = P_SETTLE;
        end
      end
      P_SETTLE: state_d = P_WAIT;
      P_WAIT: begin
        if (mu_is_ready) begin
          resp_valid = 1'b1;
          state_d    = P_IDLE;
        end
      end
      default:  state_d = P_IDLE;
    endcase
  end

  assign resp_addr = mu_addr_out;
  assign resp_data = mu_data_out;

endmodule

// File: rtl/list_walker.sv
// Walks a cons list from its root, fetching each element's contents word and
// streaming it out on a valid/ready port; aborts after MAX_LEN elements.
module list_walker
  import lisp_mem_pkg::*;
#(
  parameter int ADDR_W  = MEM_ADDR_W,
  parameter int DATA_W  = MEM_DATA_W,
  parameter int MAX_LEN = 255,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] root_addr,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [CNT_W-1:0]  count,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_index,
  output logic [1:0]        mu_func,
  output logic              mu_execute,
  output logic [ADDR_W-1:0] mu_addr0,
  output logic [ADDR_W-1:0] mu_addr1,
  input  logic              mu_is_ready,
  input  logic [ADDR_W-1:0] mu_addr_out,
  input  logic [DATA_W-1:0] mu_data_out
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_RESP, S_EMIT, S_FINISH} walk_state_t;

  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(MAX_LEN);
  localparam logic [ADDR_W-1:0] NIL      = ADDR_W'(NIL_ADDR);

  walk_state_t       state_q, state_d;
  mu_func_t          op_q, op_d;
  logic [ADDR_W-1:0] node_q, node_d, elem_q, elem_d;
  logic              busy_d, done_d, overflow_d, out_valid_d;
  logic [CNT_W-1:0]  count_d, out_index_d, count_inc;
  logic [DATA_W-1:0] out_data_d;

  logic              cmd_valid, resp_valid;
  logic [ADDR_W-1:0] cmd_addr, resp_addr;
  logic [DATA_W-1:0] resp_data;

  assign count_inc = count + 1'b1;
  assign cmd_addr  = (op_q == GET_CONTENTS) ? elem_q : node_q;
  assign mu_addr1  = '0;

  mu_cmd_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_port (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_func   (op_q),
    .cmd_addr   (cmd_addr),
    .resp_valid (resp_valid),
    .resp_addr  (resp_addr),
    .resp_data  (resp_data),
    .mu_func    (mu_func),
    .mu_execute (mu_execute),
    .mu_addr0   (mu_addr0),
    .mu_is_ready(mu_is_ready),
    .mu_addr_out(mu_addr_out),
    .mu_data_out(mu_data_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= GET_CAR;
      node_q    <= '0;
      elem_q    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      node_q    <= node_d;
      elem_q    <= elem_d;
      busy      <= busy_d;
      done      <= done_d;
      overflow  <= overflow_d;
      count     <= count_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      out_index <= out_index_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    node_d      = node_q;
    elem_d      = elem_q;
    busy_d      = busy;
    done_d      = 1'b0;
    overflow_d  = overflow;
    count_d     = count;
    out_valid_d = out_valid;
    out_data_d  = out_data;
    out_index_d = out_index;
    cmd_valid   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d     = 1'b1;
          node_d     = root_addr;
          count_d    = '0;
          overflow_d = 1'b0;
          if (root_addr == NIL) begin
            state_d = S_FINISH;
          end else begin
            op_d    = GET_CAR;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        cmd_valid = 1'b1;
        state_d   = S_WAIT_RESP;
      end
      S_WAIT_RESP: begin
        if (resp_valid) begin
          case (op_q)
            GET_CAR: begin
              elem_d  = resp_addr;
              op_d    = GET_CONTENTS;
              state_d = S_ISSUE;
            end
            GET_CONTENTS: begin
              out_data_d  = resp_data;
              out_index_d = count;
              out_valid_d = 1'b1;
              state_d     = S_EMIT;
            end
            GET_CDR: begin
              node_d = resp_addr;
              if (resp_addr == NIL) begin
                state_d = S_FINISH;
              end else begin
                op_d    = GET_CAR;
                state_d = S_ISSUE;
              end
            end
            default: state_d = S_FINISH;
          endcase
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          count_d     = count_inc;
          if (count_inc == LAST_CNT) begin
            overflow_d = 1'b1;
            state_d    = S_FINISH;
          end else begin
            op_d    = GET_CDR;
            state_d = S_ISSUE;
          end
        end
      end
      S_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_list_walker.sv
// Bench for list_walker: behavioural memory unit plus scoreboards for memory
// commands, emitted elements and walk completion.
module tb_list_walker;
  import lisp_mem_pkg::*;

  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 24;
  localparam int CNT_W   = 8;
  localparam int MAX_LEN = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] root_addr = '0;
  logic              out_ready = 1'b1;
  logic              mu_is_ready = 1'b1;
  logic [ADDR_W-1:0] mu_addr_out = '0;
  logic [DATA_W-1:0] mu_data_out = '0;
  logic              busy, done, overflow, out_valid, mu_execute;
  logic [CNT_W-1:0]  count, out_index;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        mu_func;
  logic [ADDR_W-1:0] mu_addr0, mu_addr1;

  always #5 clk = ~clk;

  list_walker #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .root_addr(root_addr),
    .busy(busy), .done(done), .overflow(overflow), .count(count),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_index(out_index),
    .mu_func(mu_func), .mu_execute(mu_execute), .mu_addr0(mu_addr0), .mu_addr1(mu_addr1),
    .mu_is_ready(mu_is_ready), .mu_addr_out(mu_addr_out), .mu_data_out(mu_data_out)
  );

  typedef struct packed { logic [1:0] func; logic [ADDR_W-1:0] addr; } cmd_t;
  typedef struct packed { logic [DATA_W-1:0] data; logic [CNT_W-1:0] idx; } out_t;
  typedef struct packed { logic [CNT_W-1:0] cnt; logic ovf; } done_t;

  cmd_t  exp_cmd[$];
  out_t  exp_out[$];
  done_t exp_done[$];

  int errors = 0;
  int checks = 0;
  int n_exec = 0;
  int n_done = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory unit model: ready drops after execute, result and ready return 4 cycles later.
  logic [DATA_W-1:0] mem [0:1023];
  int unsigned       mu_cnt = 0;
  logic [1:0]        cur_f = '0;
  logic [ADDR_W-1:0] cur_a = '0;

  always @(posedge clk) begin
    if (mu_execute) begin
      n_exec++;
      mu_is_ready <= 1'b0;
      mu_cnt      <= 4;
      cur_f       <= mu_func;
      cur_a       <= mu_addr0;
    end else if (mu_cnt != 0) begin
      mu_cnt <= mu_cnt - 1;
      if (mu_cnt == 1) begin
        mu_is_ready <= 1'b1;
        mu_addr_out <= (cur_f == GET_CDR) ? cell_cdr(mem[cur_a]) : cell_car(mem[cur_a]);
        mu_data_out <= mem[cur_a];
      end
    end
  end

  // Monitors
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      if (mu_execute) begin
        check("exec_while_ready", mu_is_ready, 1'b1);
        if (exp_cmd.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_cmd: got func %0h addr %0h expected none", mu_func, mu_addr0);
        end else begin
          cmd_t c;
          c = exp_cmd.pop_front();
          check("cmd_func", mu_func, c.func);
          check("cmd_addr", mu_addr0, c.addr);
        end
      end
      if (out_valid && out_ready) begin
        if (exp_out.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out: got data %0h index %0d expected none", out_data, out_index);
        end else begin
          out_t o;
          o = exp_out.pop_front();
          check("out_data", out_data, o.data);
          check("out_index", out_index, o.idx);
        end
      end
      if (done) begin
        n_done++;
        if (exp_done.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got count %0d expected none", count);
        end else begin
          done_t d;
          d = exp_done.pop_front();
          check("done_count", count, d.cnt);
          check("done_overflow", overflow, d.ovf);
        end
      end
    end
  end

  task automatic exp_elem(input logic [ADDR_W-1:0] node, input logic [ADDR_W-1:0] car,
                          input logic [DATA_W-1:0] val, input int idx, input bit fetch_cdr);
    exp_cmd.push_back(cmd_t'{func: GET_CAR, addr: node});
    exp_cmd.push_back(cmd_t'{func: GET_CONTENTS, addr: car});
    exp_out.push_back(out_t'{data: val, idx: CNT_W'(idx)});
    if (fetch_cdr) exp_cmd.push_back(cmd_t'{func: GET_CDR, addr: node});
  endtask

  task automatic exp_list3();
    exp_elem(10'd5, 10'd20, 24'h00A001, 0, 1'b1);
    exp_elem(10'd6, 10'd21, 24'h00A002, 1, 1'b1);
    exp_elem(10'd7, 10'd22, 24'h00A003, 2, 1'b1);
    exp_done.push_back(done_t'{cnt: CNT_W'(3), ovf: 1'b0});
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] a);
    @(negedge clk);
    start = 1'b1;
    root_addr = a;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int base, input string name);
    int k;
    k = 0;
    while (n_done <= base && k < 2000) begin
      @(negedge clk);
      k++;
    end
    #2;
    checks++;
    if (n_done <= base) begin
      errors++;
      $display("FAIL %s: got no done expected done within 2000 cycles", name);
    end
  endtask

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    while (!out_valid && k < 300) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL %s: got out_valid=0 expected 1 within 300 cycles", name);
    end
  endtask

  int   base_exec, base_done, k;
  logic [DATA_W-1:0] held_data;
  logic [CNT_W-1:0]  held_idx;
  bit   stable;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[5]  = {4'h0, 10'd20, 10'd6};
    mem[6]  = {4'h0, 10'd21, 10'd7};
    mem[7]  = {4'h0, 10'd22, 10'd0};
    mem[20] = 24'h00A001;
    mem[21] = 24'h00A002;
    mem[22] = 24'h00A003;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_count", count, '0);
    check("rst_execute", mu_execute, 1'b0);
    check("rst_outs", {overflow, out_data, out_index, mu_func, mu_addr0}, '0);
    rst = 1'b0;
    @(negedge clk);

    // Empty list
    base_exec = n_exec;
    exp_done.push_back(done_t'{cnt: '0, ovf: 1'b0});
    do_start(10'd0);
    check("empty_busy", busy, 1'b1);
    @(negedge clk);
    check("empty_done_latency", done, 1'b1);
    check("empty_busy_clear", busy, 1'b0);
    repeat (3) @(negedge clk);
    check("empty_no_exec", n_exec - base_exec, 0);

    // Three-element list
    base_exec = n_exec;
    base_done = n_done;
    exp_list3();
    do_start(10'd5);
    wait_done(base_done, "list3_done");
    check("list3_exec_count", n_exec - base_exec, 9);

    // Backpressure on element 1
    base_done = n_done;
    exp_list3();
    out_ready = 1'b0;
    do_start(10'd5);
    for (int e = 0; e < 3; e++) begin
      wait_valid("bp_valid");
      if (e == 1) begin
        held_data = out_data;
        held_idx  = out_index;
        base_exec = n_exec;
        stable    = 1'b1;
        repeat (10) begin
          @(negedge clk);
          if (out_data !== held_data || out_index !== held_idx || out_valid !== 1'b1) stable = 1'b0;
        end
        check("bp_hold_stable", stable, 1'b1);
        check("bp_no_exec", n_exec - base_exec, 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
    out_ready = 1'b1;
    wait_done(base_done, "bp_done");

    // Cyclic list: abort at MAX_LEN
    mem[5] = {4'h0, 10'd20, 10'd5};
    base_done = n_done;
    for (int e = 0; e < 4; e++) exp_elem(10'd5, 10'd20, 24'h00A001, e, e < 3);
    exp_done.push_back(done_t'{cnt: CNT_W'(4), ovf: 1'b1});
    do_start(10'd5);
    wait_done(base_done, "cyclic_done");
    mem[5] = {4'h0, 10'd20, 10'd6};

    // Reset during WAIT_RESP of element 1
    base_exec = n_exec;
    base_done = n_done;
    exp_elem(10'd5, 10'd20, 24'h00A001, 0, 1'b1);
    exp_cmd.push_back(cmd_t'{func: GET_CAR, addr: 10'd6});
    do_start(10'd5);
    k = 0;
    while (n_exec - base_exec < 4 && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("rstmid_reached", n_exec - base_exec, 4);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_outs", {done, overflow, count, out_valid, out_data, out_index, mu_execute, mu_func, mu_addr0}, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rstmid_no_done", n_done - base_done, 0);
    base_done = n_done;
    exp_list3();
    do_start(10'd5);
    wait_done(base_done, "rstmid_restart_done");

    // start while busy is ignored
    base_done = n_done;
    exp_list3();
    do_start(10'd5);
    repeat (6) @(negedge clk);
    do_start(10'd0);
    wait_done(base_done, "busy_start_done");
    repeat (20) @(negedge clk);
    check("busy_start_one_done", n_done - base_done, 1);

    check("left_cmds", exp_cmd.size(), 0);
    check("left_outs", exp_out.size(), 0);
    check("left_dones", exp_done.size(), 0);
    check("addr1_tied", mu_addr1, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1);
  end

endmodule

// File: doc/list_walker.md
Name: list_walker

Overview:
- Client of the cons-cell memory unit; sits directly upstream and drives its func/execute/addr0/addr1 command port.
- Given a list root address, walks the cdr chain and reads the car of each node.
- Fetches the contents word of each element and streams it out on a valid/ready interface.
- Used by the evaluator and the debug/print path to linearise lists.

Parameters:
- ADDR_W, 10, cell address width; equals `memory_addr_width.
- DATA_W, 24, cell word width; equals `memory_data_width.
- MAX_LEN, 255, maximum elements emitted before the walk aborts (cycle guard).
- CNT_W, 8, width of the element index and count; must hold MAX_LEN.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a walk; sampled only in IDLE.
- root_addr  in  ADDR_W  address of the first cons node; 0 = nil.
- busy  out  1  high from the cycle after start is accepted until the walk ends.
- done  out  1  one-cycle pulse when the walk ends, normally or by abort.
- overflow  out  1  valid with done; set when the walk aborts after MAX_LEN elements.
- count  out  CNT_W  number of elements emitted; valid with done.
- out_valid  out  1  element word available.
- out_ready  in  1  consumer accepts the word.
- out_data  out  DATA_W  contents word of the current element.
- out_index  out  CNT_W  0-based position of the element in the list.
- mu_func  out  2  00 CAR, 01 CDR, 11 CONTENTS; 10 (CONS) is never driven.
- mu_execute  out  1  one-cycle command strobe.
- mu_addr0  out  ADDR_W  command operand.
- mu_addr1  out  ADDR_W  tied to 0.
- mu_is_ready  in  1  memory unit is idle and its previous result is valid.
- mu_addr_out  in  ADDR_W  result of CAR/CDR.
- mu_data_out  in  DATA_W  result of CONTENTS.

Behaviour:
- Reset values:
  - All outputs 0; the FSM enters IDLE; node, elem, count and index registers are cleared.
  - Reset mid-walk abandons the walk with no done pulse.
  - A memory-unit command already in flight is left to complete; the walker ignores its result.
- Memory handshake rules:
  - mu_execute is asserted for exactly one cycle, only while mu_is_ready=1. mu_func and mu_addr0 are registered and held stable that cycle.
  - The cycle after the strobe is SETTLE: mu_is_ready is ignored because it is still stale-high.
  - From the following cycle, WAIT_RESP waits for mu_is_ready=1, then captures mu_addr_out or mu_data_out on that edge.
- States:
  - IDLE: on start, busy<=1, node<=root_addr, count<=0.
    - If root_addr==0, go to FINISH with no memory traffic.
    - Otherwise set op<=CAR and go to ISSUE.
  - ISSUE: wait for mu_is_ready, then pulse execute with op and operand. The operand is node for CAR/CDR and elem for CONTENTS.
  - SETTLE: one cycle, then WAIT_RESP.
  - WAIT_RESP, according to op:
    - CAR: elem<=mu_addr_out, op<=CONTENTS, go to ISSUE.
    - CONTENTS: out_data<=mu_data_out, out_index<=count, out_valid<=1, go to EMIT.
    - CDR: node<=mu_addr_out. If mu_addr_out==0, go to FINISH; otherwise op<=CAR and go to ISSUE.
  - EMIT: hold out_data, out_index and out_valid stable until out_ready. On the handshake cycle:
    - out_valid<=0 and count<=count+1.
    - If count+1==MAX_LEN, set overflow<=1 and go to FINISH.
    - Otherwise op<=CDR and go to ISSUE.
  - FINISH: done<=1 for one cycle, busy<=0, return to IDLE. overflow and count hold until the next accepted start.
- Per-element cost: 3 memory commands (CAR, CONTENTS, CDR). out_valid rises exactly 1 cycle after the CONTENTS result is captured.
- Edge cases:
  - start while busy is ignored.
  - An element address of 0 (nil car) is still fetched via CONTENTS; no special case.
  - count never wraps, because the walk aborts at MAX_LEN.
  - out_ready held high gives zero-stall acceptance: EMIT lasts 1 cycle.
  - The overflow check fires on the MAX_LEN-th accepted element. That element is emitted and its CDR is not fetched.

Decomposition:
- Shared package `lisp_mem_pkg`:
  - Func codes GET_CAR/GET_CDR/GET_CONS/GET_CONTENTS.
  - NIL_ADDR=0.
  - Address/data widths.
  - Cell field slices: car [19:10], cdr [9:0].
- Optional sub-module `mu_cmd_port`: the ISSUE/SETTLE/WAIT_RESP command sequencer, reusable by other memory-unit clients. The walker FSM sits on top of it.

Test Plan:
- Bench model: behavioural memory unit with the same is_ready timing (ready drops the cycle after execute, result after 4 cycles).
- Empty list: root_addr=0, start → done 2 cycles later, count=0, overflow=0, zero mu_execute pulses.
- 3-element list:
  - Cells 5→6→7 with cdr chain ending in 0; cars 20,21,22 with contents 0x00A001, 0x00A002, 0x00A003.
  - Expected: out_data sequence A001, A002, A003 with out_index 0,1,2; count=3; 9 execute pulses in order CAR, CONTENTS, CDR.
- Backpressure: same list with out_ready low for 10 cycles on element 1 → out_data/out_index held constant, no mu_execute during the stall, identical final output.
- Cyclic list: cell 5 cdr=5, MAX_LEN=4 → exactly 4 elements emitted, done with overflow=1, count=4.
- Reset mid-walk: assert rst during WAIT_RESP of element 1 → all outputs 0 next edge, no done. A new start on root 5 then completes normally.
- start while busy: a second pulse mid-walk is ignored; only one done is observed.
